// File: rtl/pim_cmd_queue.sv
// Command queue between a host start strobe and a single-outstanding compute engine.
// Optional statistics counters are enabled by defining PIM_CMD_STATS_EN.
module pim_cmd_queue #(
    parameter int LEN   = 32,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [LEN-1:0]               src1_addr,
    input  logic [LEN-1:0]               src2_addr,
    input  logic [LEN-1:0]               dst_addr,
    output logic                         cmd_valid,
    output logic [LEN-1:0]               cmd_src1,
    output logic [LEN-1:0]               cmd_src2,
    output logic [LEN-1:0]               cmd_dst,
    input  logic                         cmd_ready,
    input  logic                         eng_done,
    output logic                         busy,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
    output logic                         overflow
`ifdef PIM_CMD_STATS_EN
    ,
    output logic [15:0]                  n_accepted,
    output logic [15:0]                  n_dropped,
    output logic [15:0]                  n_done
`endif
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int EW = 3 * LEN;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            start_q, start_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            overflow_q, overflow_d;
    logic [EW-1:0]   cmd_q, cmd_d;

    logic [EW-1:0]   mem [DEPTH];

    logic            capture;
    logic            full;
    logic            pop;
    logic            push;
    logic            drop;
    logic            done_in_wait;

    // Edge detect on the strobe; a level held for many cycles yields one command.
    always_comb begin
        start_d      = start;
        capture      = start & ~start_q;
        full         = (count_q == FULL_CNT);
        pop          = (state_q == ISSUE) & cmd_ready;
        push         = capture & (~full | pop);
        drop         = capture & full & ~pop;
        done_in_wait = (state_q == WAIT) & eng_done;
    end

    always_comb begin
        wr_ptr_d   = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        overflow_d = overflow_q | drop;
        count_d    = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Command storage has no reset; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= {src1_addr, src2_addr, dst_addr};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            start_q    <= 1'b1;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            start_q    <= start_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (count_q != '0) state_d = ISSUE;
            ISSUE:   if (cmd_ready)     state_d = WAIT;
            WAIT:    if (eng_done)      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cmd_valid  = (state_q == ISSUE);
        busy       = (state_q != IDLE) | (count_q != '0);
        fifo_count = count_q;
        overflow   = overflow_q;
    end

    // The head is read once on entry to ISSUE and held until the handshake,
    // so a push landing on the same slot during a full-queue pop cannot disturb it.
    always_comb begin
        cmd_d = cmd_q;
        if ((state_q == IDLE) && (count_q != '0)) begin
            cmd_d = mem[rd_ptr_q];
        end else if (pop) begin
            cmd_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cmd_q <= '0;
        end else begin
            cmd_q <= cmd_d;
        end
    end

    assign cmd_src1 = cmd_q[EW-1:2*LEN];
    assign cmd_src2 = cmd_q[2*LEN-1:LEN];
    assign cmd_dst  = cmd_q[LEN-1:0];

`ifdef PIM_CMD_STATS_EN
    logic [2:0]  stat_inc;
    logic [15:0] stat_q [3];
    logic [15:0] stat_d [3];

    assign stat_inc = {done_in_wait, drop, push};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_stat
            always_comb begin
                stat_d[gi] = stat_q[gi];
                if (stat_inc[gi] && (stat_q[gi] != 16'hFFFF)) begin
                    stat_d[gi] = stat_q[gi] + 16'd1;
                end
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    stat_q[gi] <= '0;
                end else begin
                    stat_q[gi] <= stat_d[gi];
                end
            end
        end
    endgenerate

    assign n_accepted = stat_q[0];
    assign n_dropped  = stat_q[1];
    assign n_done     = stat_q[2];
`else
    logic unused_stats;
    assign unused_stats = done_in_wait;
`endif

endmodule

// File: tb/tb_pim_cmd_queue.sv
// Randomized and directed bench for pim_cmd_queue against a queue-based reference model.
module tb_pim_cmd_queue;

    localparam int LEN   = 32;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic            clk;
    logic            rst;
    logic            start;
    logic [LEN-1:0]  src1_addr, src2_addr, dst_addr;
    logic            cmd_valid;
    logic [LEN-1:0]  cmd_src1, cmd_src2, cmd_dst;
    logic            cmd_ready;
    logic            eng_done;
    logic            busy;
    logic [CW-1:0]   fifo_count;
    logic            overflow;
`ifdef PIM_CMD_STATS_EN
    logic [15:0]     n_accepted, n_dropped, n_done;
`endif

    pim_cmd_queue #(.LEN(LEN), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .src1_addr  (src1_addr),
        .src2_addr  (src2_addr),
        .dst_addr   (dst_addr),
        .cmd_valid  (cmd_valid),
        .cmd_src1   (cmd_src1),
        .cmd_src2   (cmd_src2),
        .cmd_dst    (cmd_dst),
        .cmd_ready  (cmd_ready),
        .eng_done   (eng_done),
        .busy       (busy),
        .fifo_count (fifo_count),
        .overflow   (overflow)
`ifdef PIM_CMD_STATS_EN
        ,
        .n_accepted (n_accepted),
        .n_dropped  (n_dropped),
        .n_done     (n_done)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int dut_hs   = 0;

    // Reference model: pending commands, engine phase (0 idle, 1 offered, 2 running).
    logic [3*LEN-1:0] m_q[$];
    int               m_phase;
    bit               m_start_prev;
    bit               m_over;
    int               m_acc, m_drop, m_done, m_issued;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        m_q.delete();
        m_phase      = 0;
        m_start_prev = 1'b1;
        m_over       = 1'b0;
        m_acc        = 0;
        m_drop       = 0;
        m_done       = 0;
    endfunction

    function automatic void model_step();
        bit cap, full, pop;
        int nph;
        logic [3*LEN-1:0] c;
        if (!rst) begin
            model_reset();
            return;
        end
        cap          = start && !m_start_prev;
        m_start_prev = start;
        full         = (m_q.size() == DEPTH);
        pop          = (m_phase == 1) && cmd_ready;
        nph          = m_phase;
        case (m_phase)
            0: if (m_q.size() != 0) nph = 1;
            1: if (cmd_ready) nph = 2;
            2: if (eng_done) begin nph = 0; if (m_done < 65535) m_done++; end
            default: nph = 0;
        endcase
        if (pop) begin
            c = m_q.pop_front();
            m_issued++;
            $display("issue #%0d src1=%0h src2=%0h dst=%0h", m_issued,
                     c[3*LEN-1:2*LEN], c[2*LEN-1:LEN], c[LEN-1:0]);
        end
        if (cap) begin
            if (full && !pop) begin
                m_over = 1'b1;
                if (m_drop < 65535) m_drop++;
            end else begin
                m_q.push_back({src1_addr, src2_addr, dst_addr});
                if (m_acc < 65535) m_acc++;
            end
        end
        m_phase = nph;
    endfunction

    task automatic compare();
        logic [3*LEN-1:0] h;
        chk("valid", cmd_valid, (m_phase == 1));
        chk("busy", busy, (m_phase != 0 || m_q.size() != 0));
        chk("count", fifo_count, m_q.size());
        chk("overflow", overflow, m_over);
        if (m_phase == 1 && m_q.size() != 0) begin
            h = m_q[0];
            chk("src1", cmd_src1, h[3*LEN-1:2*LEN]);
            chk("src2", cmd_src2, h[2*LEN-1:LEN]);
            chk("dst", cmd_dst, h[LEN-1:0]);
        end
`ifdef PIM_CMD_STATS_EN
        chk("n_accepted", n_accepted, m_acc);
        chk("n_dropped", n_dropped, m_drop);
        chk("n_done", n_done, m_done);
`endif
    endtask

    // One clock: inputs already set by caller; model follows the edge, outputs checked at negedge.
    task automatic step();
        #1;
        if (cmd_valid && cmd_ready && rst) dut_hs++;
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
    endtask

    task automatic pulse_fill(input int n);
        for (int i = 0; i < n; i++) begin
            start     = 1'b1;
            src1_addr = $urandom;
            src2_addr = $urandom;
            dst_addr  = $urandom;
            step();
            start = 1'b0;
            step();
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step();
        rst = 1'b1;
        step();
    endtask

    int hs0;

    initial begin
        rst       = 1'b0;
        start     = 1'b1;
        src1_addr = '0;
        src2_addr = '0;
        dst_addr  = '0;
        cmd_ready = 1'b0;
        eng_done  = 1'b0;
        m_issued  = 0;
        model_reset();

        // Reset state, and start held across reset release must not capture.
        step();
        step();
        rst = 1'b1;
        step();
        step();
        chk("no_capture_at_release", fifo_count, 0);
        start = 1'b0;
        step();

        // Held start: one command, two-edge latency, count back to zero.
        src1_addr = 100; src2_addr = 200; dst_addr = 300;
        cmd_ready = 1'b1;
        start     = 1'b1;
        hs0       = dut_hs;
        step();
        chk("latency_edge1", cmd_valid, 1'b0);
        step();
        chk("latency_edge2", cmd_valid, 1'b1);
        chk("held_src1", cmd_src1, 100);
        chk("held_dst", cmd_dst, 300);
        step(); step(); step();
        start = 1'b0;
        step(); step(); step();
        chk("single_issue", dut_hs - hs0, 1);
        chk("held_count", fifo_count, 0);
        eng_done = 1'b1; step();
        eng_done = 1'b0; step();
        chk("done_to_idle", busy, 1'b0);

        // eng_done while idle is ignored.
        eng_done = 1'b1; step();
        eng_done = 1'b0; step();
        chk("done_in_idle", cmd_valid, 1'b0);

        // Overflow: six pulses into a stalled four-entry queue.
        cmd_ready = 1'b0;
        pulse_fill(6);
        chk("ovf_count", fifo_count, DEPTH);
        chk("ovf_flag", overflow, 1'b1);
`ifdef PIM_CMD_STATS_EN
        chk("ovf_dropped", n_dropped, 2);
`endif
        eng_done = 1'b1; step();
        eng_done = 1'b0; step();
        chk("done_in_issue", cmd_valid, 1'b1);
        hs0 = dut_hs;
        for (int i = 0; i < 24; i++) begin
            cmd_ready = 1'b1;
            eng_done  = (i % 3 == 2);
            step();
        end
        eng_done  = 1'b0;
        cmd_ready = 1'b0;
        chk("drain_issued", dut_hs - hs0, DEPTH);
        chk("drain_count", fifo_count, 0);

        // Full queue: capture coinciding with a pop is accepted.
        do_reset();
        start = 1'b0;
        pulse_fill(DEPTH);
        start     = 1'b1;
        cmd_ready = 1'b1;
        src1_addr = 32'hA1; src2_addr = 32'hA2; dst_addr = 32'hA3;
        step();
        start     = 1'b0;
        cmd_ready = 1'b0;
        chk("full_pop_ovf", overflow, 1'b0);
        chk("full_pop_count", fifo_count, DEPTH);
        step();

        // Reset mid-WAIT with three queued.
        do_reset();
        start = 1'b0;
        pulse_fill(DEPTH);
        cmd_ready = 1'b1;
        step();
        cmd_ready = 1'b0;
        chk("pre_rst_count", fifo_count, DEPTH - 1);
        start = 1'b1;
        #2 rst = 1'b0;
        #1;
        chk("async_valid", cmd_valid, 1'b0);
        chk("async_busy", busy, 1'b0);
        chk("async_count", fifo_count, 0);
        model_reset();
        step();
        rst = 1'b1;
        step(); step(); step();
        chk("post_rst_count", fifo_count, 0);
        chk("post_rst_busy", busy, 1'b0);
        start = 1'b0;
        step();

        // Random traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            rst       = ($urandom_range(0, 199) != 0);
            start     = ($urandom_range(0, 2) == 0);
            src1_addr = $urandom;
            src2_addr = $urandom;
            dst_addr  = $urandom;
            cmd_ready = ($urandom_range(0, 2) != 0);
            eng_done  = ($urandom_range(0, 3) == 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/pim_cmd_queue.md
PIM_CMD_QUEUE -- requirements
Module: pim_cmd_queue

Interface
REQ-001 SHALL have parameter LEN, default 32, address width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, command FIFO entries (power of two, >=2).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; asynchronous, active-low (asserted at 0).
REQ-005 SHALL have port start  input  1  host command strobe; level may be held multiple cycles.
REQ-006 SHALL have ports src1_addr, src2_addr, dst_addr  input  LEN each  host command operands.
REQ-007 SHALL have port cmd_valid  output  1  command offered to compute engine.
REQ-008 SHALL have ports cmd_src1, cmd_src2, cmd_dst  output  LEN each  offered command operands.
REQ-009 SHALL have port cmd_ready  input  1  engine accepts offered command.
REQ-010 SHALL have port eng_done  input  1  single-cycle engine completion pulse.
REQ-011 SHALL have port busy  output  1  queue non-empty or command in flight.
REQ-012 SHALL have port fifo_count  output  $clog2(DEPTH+1)  queued entries.
REQ-013 SHALL have port overflow  output  1  sticky: a command was dropped.

Function
REQ-014 SHALL register start into start_q each cycle; capture event = start & !start_q.
REQ-015 SHALL, on a capture event, push {src1_addr, src2_addr, dst_addr} sampled that cycle; fifo_count reflects it the next cycle.
REQ-016 SHALL, on a capture event with FIFO full and no pop that cycle, drop the command and set overflow.
REQ-017 SHALL, on a capture event with FIFO full and a simultaneous pop, accept the push; count stays DEPTH.
REQ-018 SHALL wrap read and write pointers modulo DEPTH; count never exceeds DEPTH or underflows.
REQ-019 SHALL implement FSM IDLE, ISSUE, WAIT.
REQ-020 SHALL in IDLE: cmd_valid=0; if fifo_count!=0 go to ISSUE.
REQ-021 SHALL in ISSUE: cmd_valid=1, cmd_* = FIFO head, held stable until cmd_ready; on cmd_valid&cmd_ready pop head and go to WAIT.
REQ-022 SHALL in WAIT: cmd_valid=0; on eng_done go to IDLE.
REQ-023 SHALL ignore eng_done outside WAIT.
REQ-024 SHALL yield minimum latency: capture at edge N, cmd_valid high after edge N+2 when idle and empty.
REQ-025 SHALL drive busy = (state!=IDLE) | (fifo_count!=0).
REQ-026 SHALL allow at most one command outstanding at the engine.

Reset
REQ-027 SHALL, while rst=0, asynchronously force state=IDLE, cmd_valid=0, cmd_*=0, fifo_count=0, pointers=0, overflow=0, busy=0.
REQ-028 SHALL reset start_q to 1 so a start held high across reset release is not captured.
REQ-029 SHALL on reset mid-operation discard all queued and in-flight commands; no pulse replay.

Configuration
REQ-030 SHALL, with macro PIM_CMD_STATS_EN defined, add 16-bit outputs n_accepted, n_dropped, n_done, reset to 0, incremented on push, drop, and eng_done-in-WAIT respectively, saturating at 0xFFFF.
REQ-031 SHALL, without PIM_CMD_STATS_EN, omit those ports and counters; all other behaviour identical.

Verification
REQ-032 SHALL cover: start held 5 cycles with src1=100,src2=200,dst=300, cmd_ready=1 -> exactly one cmd_valid with 100/200/300, fifo_count returns 0.
REQ-033 SHALL cover: cmd_ready=0, 6 start pulses with DEPTH=4 -> fifo_count=4, overflow=1, n_dropped=2 (stats on); then ready -> 4 commands issued in order.
REQ-034 SHALL cover: FIFO full, ISSUE handshake same cycle as capture event -> push accepted, overflow stays 0.
REQ-035 SHALL cover: eng_done pulsed in IDLE and ISSUE -> no state change; in WAIT -> IDLE next cycle, n_done+1.
REQ-036 SHALL cover: rst=0 asserted mid-WAIT with 3 queued -> cmd_valid, busy, fifo_count 0 immediately; start high at release -> no capture.
